// File: rtl/pixel_mem_arbiter.sv
// Arbitrates the single-port pixel memory between CPU loads/stores (through a
// one-entry posted write buffer) and the video scanout reader.
module pixel_mem_arbiter #(
  parameter int unsigned N        = 32,
  parameter int unsigned AW       = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic [N-1:0]  cpu_rdata,
  output logic          cpu_rvalid,
  output logic          stall,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic [N-1:0]  vid_rdata,
  output logic          vid_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, RD_DATA} state_e;

  state_e          state_q;
  logic            wb_valid_q;
  logic [AW-1:0]   wb_addr_q;
  logic [N-1:0]    wb_data_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            fwd_q;
  logic [N-1:0]    fwd_data_q;
  logic            vid_rvalid_q;

  logic [AW-1:0]   cpu_idx;
  logic            st_req, ld_req, hit, load_pend, drain_pend, cpu_pend;
  logic            override, gnt_vid, gnt_ld, gnt_dr, st_acc;
  logic            unused_addr_bits;

  assign cpu_idx          = cpu_addr[AW+1:2];
  assign unused_addr_bits = ^{cpu_addr[N-1:AW+2], cpu_addr[1:0]};

  always_comb begin
    // Requests are only taken in IDLE; reset masks every grant in its cycle.
    st_req     = (state_q == IDLE) && !rst && cpu_we;
    ld_req     = (state_q == IDLE) && !rst && cpu_re && !cpu_we;
    hit        = wb_valid_q && (wb_addr_q == cpu_idx);
    load_pend  = ld_req && !hit;
    drain_pend = wb_valid_q && !rst;
    cpu_pend   = load_pend || drain_pend;
    override   = (wait_cnt_q == CW'(MAX_WAIT));
    gnt_vid    = vid_req && !rst && !(override && cpu_pend);
    gnt_ld     = !gnt_vid && load_pend;
    gnt_dr     = !gnt_vid && !load_pend && drain_pend;
    st_acc     = st_req && (!wb_valid_q || gnt_dr);
    stall      = (st_req && !st_acc) || ld_req;

    mem_en    = gnt_vid || gnt_ld || gnt_dr;
    mem_we    = gnt_dr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vid)     mem_addr = vid_addr;
    else if (gnt_ld) mem_addr = cpu_idx;
    else if (gnt_dr) begin
      mem_addr  = wb_addr_q;
      mem_wdata = wb_data_q;
    end
  end

  assign vid_gnt    = gnt_vid;
  assign vid_rvalid = vid_rvalid_q;
  assign vid_rdata  = vid_rvalid_q ? mem_rdata : '0;
  assign cpu_rvalid = (state_q == RD_DATA);
  assign cpu_rdata  = (state_q != RD_DATA) ? '0 : (fwd_q ? fwd_data_q : mem_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wait_cnt_q   <= '0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
      vid_rvalid_q <= 1'b0;
    end else begin
      state_q      <= (ld_req && (hit || gnt_ld)) ? RD_DATA : IDLE;
      fwd_q        <= ld_req && hit;
      vid_rvalid_q <= gnt_vid;
      if (ld_req && hit) fwd_data_q <= wb_data_q;

      if (st_acc) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= cpu_idx;
        wb_data_q  <= cpu_wdata;
      end else if (gnt_dr) begin
        wb_valid_q <= 1'b0;
      end

      if (gnt_ld || gnt_dr || !cpu_pend) wait_cnt_q <= '0;
      else if (!override)                wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

endmodule
